// File: rtl/otter_exec_unit_if.sv
// Execute-stage bus for the OTTER core: operands, immediates, PC and the
// combinational/registered ALU, branch-target and compare results.
interface otter_exec_unit_if;
    // Load enable for the EX/MEM result register
    logic        EN;

    // Operands and control
    logic [31:0] SRC_A;
    logic [31:0] SRC_B;
    logic [3:0]  ALU_FUN;
    logic [31:0] RS1;
    logic [31:0] RS2;
    logic [31:0] FROM_PC;
    logic [31:0] I_TYPE;
    logic [31:0] J_TYPE;
    logic [31:0] B_TYPE;

    // Combinational results
    logic [31:0] RESULT;
    logic [31:0] JAL;
    logic [31:0] JALR;
    logic [31:0] BRANCH;
    logic        BR_EQ;
    logic        BR_LT;
    logic        BR_LTU;

    // Registered results
    logic [31:0] RESULT_Q;
    logic [31:0] JAL_Q;
    logic [31:0] JALR_Q;
    logic [31:0] BRANCH_Q;
    logic        BR_EQ_Q;
    logic        BR_LT_Q;
    logic        BR_LTU_Q;

    // Upstream pipeline side: drives operands, observes results
    modport master (
        output EN, SRC_A, SRC_B, ALU_FUN, RS1, RS2, FROM_PC, I_TYPE, J_TYPE, B_TYPE,
        input  RESULT, JAL, JALR, BRANCH, BR_EQ, BR_LT, BR_LTU,
        input  RESULT_Q, JAL_Q, JALR_Q, BRANCH_Q, BR_EQ_Q, BR_LT_Q, BR_LTU_Q
    );

    // Execute unit side: consumes operands, produces results
    modport slave (
        input  EN, SRC_A, SRC_B, ALU_FUN, RS1, RS2, FROM_PC, I_TYPE, J_TYPE, B_TYPE,
        output RESULT, JAL, JALR, BRANCH, BR_EQ, BR_LT, BR_LTU,
        output RESULT_Q, JAL_Q, JALR_Q, BRANCH_Q, BR_EQ_Q, BR_LT_Q, BR_LTU_Q
    );
endinterface

// File: rtl/otter_exec_unit.sv
// OTTER execute stage: ALU, branch address generator and branch condition
// generator, all combinational, plus an enabled EX/MEM result register.
module otter_exec_unit (
    input  logic                CLK,
    input  logic                RST,   // active-low, asynchronous
    otter_exec_unit_if.slave    bus
);

    // ALU_FUN encodings (bit 3 selects SUB/SRA variants of ADD/SRL)
    localparam logic [3:0] AluAdd  = 4'b0000;
    localparam logic [3:0] AluSll  = 4'b0001;
    localparam logic [3:0] AluSlt  = 4'b0010;
    localparam logic [3:0] AluSltu = 4'b0011;
    localparam logic [3:0] AluXor  = 4'b0100;
    localparam logic [3:0] AluSrl  = 4'b0101;
    localparam logic [3:0] AluOr   = 4'b0110;
    localparam logic [3:0] AluAnd  = 4'b0111;
    localparam logic [3:0] AluSub  = 4'b1000;
    localparam logic [3:0] AluLui  = 4'b1001;
    localparam logic [3:0] AluSra  = 4'b1101;

    logic [31:0] w_result;
    logic [31:0] w_jal;
    logic [31:0] w_jalr_sum;
    logic [31:0] w_jalr;
    logic [31:0] w_branch;
    logic        w_br_eq;
    logic        w_br_lt;
    logic        w_br_ltu;
    logic [4:0]  w_shamt;

    logic [31:0] r_result;
    logic [31:0] r_jal;
    logic [31:0] r_jalr;
    logic [31:0] r_branch;
    logic        r_br_eq;
    logic        r_br_lt;
    logic        r_br_ltu;

    // Only the low five bits of B form the shift amount
    assign w_shamt = bus.SRC_B[4:0];

    // ALU result select; unused codes yield zero
    always_comb begin
        w_result = 32'h0;
        case (bus.ALU_FUN)
            AluAdd:  w_result = bus.SRC_A + bus.SRC_B;
            AluSub:  w_result = bus.SRC_A - bus.SRC_B;
            AluSll:  w_result = bus.SRC_A << w_shamt;
            AluSlt:  w_result = {31'h0, $signed(bus.SRC_A) < $signed(bus.SRC_B)};
            AluSltu: w_result = {31'h0, bus.SRC_A < bus.SRC_B};
            AluXor:  w_result = bus.SRC_A ^ bus.SRC_B;
            AluSrl:  w_result = bus.SRC_A >> w_shamt;
            AluSra:  w_result = $unsigned($signed(bus.SRC_A) >>> w_shamt);
            AluOr:   w_result = bus.SRC_A | bus.SRC_B;
            AluAnd:  w_result = bus.SRC_A & bus.SRC_B;
            AluLui:  w_result = bus.SRC_A;
            default: w_result = 32'h0;
        endcase
    end

    // Branch/jump targets wrap modulo 2^32; JALR target is halfword aligned
    assign w_jal      = bus.FROM_PC + bus.J_TYPE;
    assign w_branch   = bus.FROM_PC + bus.B_TYPE;
    assign w_jalr_sum = bus.RS1 + bus.I_TYPE;
    assign w_jalr     = {w_jalr_sum[31:1], 1'b0};

    // Branch condition flags
    assign w_br_eq  = (bus.RS1 == bus.RS2);
    assign w_br_lt  = ($signed(bus.RS1) < $signed(bus.RS2));
    assign w_br_ltu = (bus.RS1 < bus.RS2);

    // EX/MEM register: async clear, load on EN, otherwise hold
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_result <= 32'h0;
            r_jal    <= 32'h0;
            r_jalr   <= 32'h0;
            r_branch <= 32'h0;
            r_br_eq  <= 1'b0;
            r_br_lt  <= 1'b0;
            r_br_ltu <= 1'b0;
        end else if (bus.EN) begin
            r_result <= w_result;
            r_jal    <= w_jal;
            r_jalr   <= w_jalr;
            r_branch <= w_branch;
            r_br_eq  <= w_br_eq;
            r_br_lt  <= w_br_lt;
            r_br_ltu <= w_br_ltu;
        end
    end

    assign bus.RESULT   = w_result;
    assign bus.JAL      = w_jal;
    assign bus.JALR     = w_jalr;
    assign bus.BRANCH   = w_branch;
    assign bus.BR_EQ    = w_br_eq;
    assign bus.BR_LT    = w_br_lt;
    assign bus.BR_LTU   = w_br_ltu;

    assign bus.RESULT_Q = r_result;
    assign bus.JAL_Q    = r_jal;
    assign bus.JALR_Q   = r_jalr;
    assign bus.BRANCH_Q = r_branch;
    assign bus.BR_EQ_Q  = r_br_eq;
    assign bus.BR_LT_Q  = r_br_lt;
    assign bus.BR_LTU_Q = r_br_ltu;

endmodule

// File: tb/tb_otter_exec_unit.sv
// Self-checking bench for otter_exec_unit: expected results are pushed to a
// scoreboard queue when stimulus is applied and popped when outputs are sampled.
module tb_otter_exec_unit;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] jal;
        logic [31:0] jalr;
        logic [31:0] branch;
        logic        eq;
        logic        lt;
        logic        ltu;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    vec_t sb_q[$];

    otter_exec_unit_if bus ();

    otter_exec_unit dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t comb_out();
        return {bus.RESULT, bus.JAL, bus.JALR, bus.BRANCH, bus.BR_EQ, bus.BR_LT, bus.BR_LTU};
    endfunction

    function automatic vec_t reg_out();
        return {bus.RESULT_Q, bus.JAL_Q, bus.JALR_Q, bus.BRANCH_Q,
                bus.BR_EQ_Q, bus.BR_LT_Q, bus.BR_LTU_Q};
    endfunction

    // Independent reference for the random sweep
    function automatic logic [31:0] ref_alu(logic [3:0] f, logic [31:0] a, logic [31:0] b);
        logic signed [31:0] sa;
        int unsigned sh;
        sa = a;
        sh = b % 32;
        case (f)
            4'd0:  return a + b;
            4'd8:  return a + ~b + 32'd1;
            4'd1:  return a << sh;
            4'd2:  return (sa < $signed(b)) ? 32'd1 : 32'd0;
            4'd3:  return (a < b) ? 32'd1 : 32'd0;
            4'd4:  return a ^ b;
            4'd5:  return a >> sh;
            4'd13: return sa >>> sh;
            4'd6:  return a | b;
            4'd7:  return a & b;
            4'd9:  return a;
            default: return 32'd0;
        endcase
    endfunction

    function automatic vec_t ref_all(logic [3:0] f, logic [31:0] a, logic [31:0] b,
                                     logic [31:0] rs1, logic [31:0] rs2, logic [31:0] pc,
                                     logic [31:0] iimm, logic [31:0] jimm, logic [31:0] bimm);
        vec_t v;
        v.result = ref_alu(f, a, b);
        v.jal    = pc + jimm;
        v.branch = pc + bimm;
        v.jalr   = (rs1 + iimm) & 32'hFFFF_FFFE;
        v.eq     = (rs1 == rs2);
        v.lt     = ($signed(rs1) < $signed(rs2));
        v.ltu    = (rs1 < rs2);
        return v;
    endfunction

    task automatic drive(logic [3:0] f, logic [31:0] a, logic [31:0] b,
                         logic [31:0] rs1, logic [31:0] rs2, logic [31:0] pc,
                         logic [31:0] iimm, logic [31:0] jimm, logic [31:0] bimm);
        bus.ALU_FUN = f;
        bus.SRC_A   = a;
        bus.SRC_B   = b;
        bus.RS1     = rs1;
        bus.RS2     = rs2;
        bus.FROM_PC = pc;
        bus.I_TYPE  = iimm;
        bus.J_TYPE  = jimm;
        bus.B_TYPE  = bimm;
    endtask

    task automatic test_reset();
        vec_t got;
        #2;
        got = reg_out();
        checks++;
        if (got !== '0) begin
            failures++;
            $display("FAIL reset_q got=%h exp=%h", got, 131'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_alu_sweep();
        logic [3:0]  funs[12] = '{4'b0000, 4'b1000, 4'b0001, 4'b0101, 4'b1101, 4'b0010,
                                  4'b0011, 4'b0111, 4'b0110, 4'b0100, 4'b1001, 4'b1111};
        logic [31:0] exps[12] = '{32'h0000_0014, 32'hFFFF_FFCC, 32'hFFFF_FF00, 32'h0FFF_FFFF,
                                  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0000_0020,
                                  32'hFFFF_FFF4, 32'hFFFF_FFD4, 32'hFFFF_FFF0, 32'h0000_0000};
        vec_t e;
        logic [31:0] got;
        for (int i = 0; i < 12; i++) begin
            drive(funs[i], 32'hFFFF_FFF0, 32'h0000_0024, 0, 0, 0, 0, 0, 0);
            e = '0;
            e.result = exps[i];
            sb_q.push_back(e);
            #1;
            got = bus.RESULT;
            e = sb_q.pop_front();
            checks++;
            if (got !== e.result) begin
                failures++;
                $display("FAIL alu_sweep fun=%b got=%h exp=%h", funs[i], got, e.result);
            end
        end
    endtask

    task automatic test_bag();
        logic [95:0] got;
        logic [95:0] exp;
        drive(4'b0000, 0, 0, 32'h0000_2003, 0, 32'h0000_1000, 32'h0000_0004,
              32'hFFFF_FFFC, 32'h0000_0010);
        sb_q.push_back('{result: 0, jal: 32'h0000_0FFC, jalr: 32'h0000_2006,
                         branch: 32'h0000_1010, eq: 0, lt: 0, ltu: 0});
        #1;
        got = {bus.JAL, bus.BRANCH, bus.JALR};
        begin
            vec_t e;
            e = sb_q.pop_front();
            exp = {e.jal, e.branch, e.jalr};
        end
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL bag got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_bcg();
        logic [31:0] rs1s[3] = '{32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_0001};
        logic [31:0] rs2s[3] = '{32'h0000_0001, 32'h0000_0005, 32'hFFFF_FFFF};
        logic [2:0]  flags[3] = '{3'b010, 3'b100, 3'b001};
        logic [2:0]  got;
        vec_t e;
        for (int i = 0; i < 3; i++) begin
            drive(4'b0000, 0, 0, rs1s[i], rs2s[i], 0, 0, 0, 0);
            e = '0;
            {e.eq, e.lt, e.ltu} = flags[i];
            sb_q.push_back(e);
            #1;
            got = {bus.BR_EQ, bus.BR_LT, bus.BR_LTU};
            e = sb_q.pop_front();
            checks++;
            if (got !== {e.eq, e.lt, e.ltu}) begin
                failures++;
                $display("FAIL bcg%0d got=%b exp=%b", i, got, {e.eq, e.lt, e.ltu});
            end
        end
    endtask

    task automatic test_wrap();
        vec_t e;
        logic [63:0] got;
        drive(4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 32'hFFFF_FFFC, 0, 32'h0000_0008, 0);
        e = '0;
        e.result = 32'h0;
        e.jal    = 32'h0000_0004;
        sb_q.push_back(e);
        #1;
        got = {bus.RESULT, bus.JAL};
        e = sb_q.pop_front();
        checks++;
        if (got !== {e.result, e.jal}) begin
            failures++;
            $display("FAIL wrap got=%h exp=%h", got, {e.result, e.jal});
        end
    endtask

    task automatic test_random();
        logic [31:0] v[8];
        logic [3:0]  f;
        vec_t e;
        vec_t got;
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < 8; k++) v[k] = $urandom;
            f = 4'($urandom_range(0, 15));
            if (n % 5 == 0) v[1] = v[0];        // hit equal operands / RS1==RS2
            drive(f, v[0], v[1], v[2], (n % 5 == 0) ? v[2] : v[3], v[4], v[5], v[6], v[7]);
            sb_q.push_back(ref_all(f, v[0], v[1], v[2], (n % 5 == 0) ? v[2] : v[3],
                                   v[4], v[5], v[6], v[7]));
            #1;
            got = comb_out();
            e = sb_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL random%0d fun=%b got=%h exp=%h", n, f, got, e);
            end
        end
    endtask

    task automatic test_register();
        vec_t e;
        vec_t got;
        @(negedge clk);
        bus.EN = 1'b1;
        drive(4'b0000, 32'd1, 32'd2, 32'd7, 32'd7, 32'h100, 32'd2, 32'h20, 32'h8);
        e = '{result: 32'd3, jal: 32'h120, jalr: 32'h8, branch: 32'h108, eq: 1, lt: 0, ltu: 0};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = reg_out();
        e = sb_q.pop_front();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL reg_load got=%h exp=%h", got, e);
        end
        @(negedge clk);
        bus.EN = 1'b0;
        drive(4'b0000, 32'd10, 32'd20, 32'd1, 32'd9, 32'h400, 32'd6, 32'h4, 32'h4);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = reg_out();
        e = sb_q.pop_front();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL reg_hold got=%h exp=%h", got, e);
        end
    endtask

    task automatic test_back_to_back();
        vec_t e;
        vec_t got;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                got = reg_out();
                e = sb_q.pop_front();
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL b2b%0d got=%h exp=%h", i, got, e);
                end
            end
            if (i < 6) begin
                bus.EN = 1'b1;
                a = 32'(i * 1000 + 17);
                b = 32'(i * 3 + 1);
                drive(4'(i % 2 == 0 ? 4'b1000 : 4'b0101), a, b, b, a, a, b, a, b);
                sb_q.push_back(ref_all(4'(i % 2 == 0 ? 4'b1000 : 4'b0101), a, b, b, a, a, b, a, b));
            end
        end
        bus.EN = 1'b0;
    endtask

    task automatic test_async_reset();
        vec_t e;
        vec_t got;
        logic [31:0] gr;
        // Load a nonzero state first
        @(negedge clk);
        bus.EN = 1'b1;
        drive(4'b0110, 32'hA5A5_0000, 32'h0000_5A5A, 32'h33, 32'h33, 32'h800, 32'h5, 32'h10, 32'h20);
        @(posedge clk);
        // Mid-cycle reset, well before the next edge
        #3;
        rst_n = 1'b0;
        #1;
        got = reg_out();
        checks++;
        if (got !== '0) begin
            failures++;
            $display("FAIL async_clear got=%h exp=%h", got, 131'h0);
        end
        // Combinational path untouched by reset
        gr = bus.RESULT;
        checks++;
        if (gr !== 32'hA5A5_5A5A) begin
            failures++;
            $display("FAIL comb_in_reset got=%h exp=%h", gr, 32'hA5A5_5A5A);
        end
        // Enabled edge while reset held
        @(posedge clk);
        #1;
        got = reg_out();
        checks++;
        if (got !== '0) begin
            failures++;
            $display("FAIL reset_over_edge got=%h exp=%h", got, 131'h0);
        end
        // Release between edges; next enabled edge loads
        @(negedge clk);
        rst_n = 1'b1;
        e = '{result: 32'hA5A5_5A5A, jal: 32'h810, jalr: 32'h38, branch: 32'h820,
              eq: 1, lt: 0, ltu: 0};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = reg_out();
        e = sb_q.pop_front();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL post_release got=%h exp=%h", got, e);
        end
        bus.EN = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.EN   = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_alu_sweep();
        test_bag();
        test_bcg();
        test_wrap();
        test_random();
        test_register();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
